// File: rtl/fetch_arb_pkg.sv
// Shared types and constants for the FETCH port arbiter.
// Optional watchdog: define FETCH_ARB_TIMEOUT_EN.
package fetch_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN
  } state_t;

  localparam int NTHREADS_DEF = 4;
  localparam logic [31:0] REG_WINDOW_BASE = 32'hFFFF_FFF0;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Search starts one past last_grant and wraps.
module rr_pick
  import fetch_arb_pkg::*;
#(
  parameter int N = NTHREADS_DEF,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_grant,
  output logic         valid,
  output logic [W-1:0] index
);

  int c;

  // Walk the ring backwards so the nearest requester wins
  always_comb begin
    valid = 1'b0;
    index = '0;
    c     = 0;
    for (int i = N; i >= 1; i--) begin
      c = (int'(last_grant) + i) % N;
      if (req[c]) begin
        valid = 1'b1;
        index = W'(c);
      end
    end
  end

endmodule

// File: rtl/fetch_arbiter.sv
// Arbitrates NTHREADS requesters onto one FETCH port.
// Optional watchdog: define FETCH_ARB_TIMEOUT_EN.
module fetch_arbiter
  import fetch_arb_pkg::*;
#(
  parameter int NTHREADS = NTHREADS_DEF,
  parameter int TIMEOUT  = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NTHREADS-1:0]         req,
  input  logic [NTHREADS-1:0]         wr,
  input  logic [32*NTHREADS-1:0]      addr_i,
  input  logic [32*NTHREADS-1:0]      wdata_i,
  output logic [NTHREADS-1:0]         done,
  output logic                        err,
  output logic [31:0]                 rdata,
  output logic                        f_enable,
  output logic                        f_write,
  output logic [31:0]                 f_addr,
  output logic [31:0]                 f_data,
  output logic [idx_w(NTHREADS)-1:0]  f_thread,
  input  logic                        f_ack,
  input  logic [31:0]                 f_rdata
);

  localparam int W = idx_w(NTHREADS);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("fetch_arbiter: TIMEOUT must be 1..255");
  end

  state_t               state_q, state_d;
  logic [W-1:0]         last_q, last_d;
  logic                 en_d, wr_d;
  logic [31:0]          addr_d, data_d, rdata_d;
  logic [W-1:0]         sel_d;
  logic [NTHREADS-1:0]  done_d;
  logic                 pick_v;
  logic [W-1:0]         pick_i;
  logic                 tmo;

  rr_pick #(
    .N(NTHREADS),
    .W(W)
  ) u_pick (
    .req       (req),
    .last_grant(last_q),
    .valid     (pick_v),
    .index     (pick_i)
  );

`ifdef FETCH_ARB_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       err_q;

  assign tmo = (cnt_q == 8'(TIMEOUT - 1));
  assign err = err_q;

  // Watchdog: count BUSY cycles, flag an abort on expiry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= (state_q == BUSY) && !f_ack && tmo;
      if (state_q == BUSY && !f_ack && !tmo)
        cnt_q <= cnt_q + 8'd1;
      else
        cnt_q <= '0;
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  // Next-state and next-output decode
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    en_d    = f_enable;
    wr_d    = f_write;
    addr_d  = f_addr;
    data_d  = f_data;
    sel_d   = f_thread;
    rdata_d = rdata;
    done_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_v) begin
          sel_d   = pick_i;
          last_d  = pick_i;
          wr_d    = wr[pick_i];
          addr_d  = addr_i[32*int'(pick_i) +: 32];
          data_d  = wdata_i[32*int'(pick_i) +: 32];
          en_d    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (f_ack || tmo) begin
          en_d             = 1'b0;
          done_d[f_thread] = 1'b1;
          if (f_ack && !f_write)
            rdata_d = f_rdata;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!f_ack)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= W'(NTHREADS - 1);
      f_enable <= 1'b0;
      f_write  <= 1'b0;
      f_addr   <= '0;
      f_data   <= '0;
      f_thread <= '0;
      rdata    <= '0;
      done     <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      f_enable <= en_d;
      f_write  <= wr_d;
      f_addr   <= addr_d;
      f_data   <= data_d;
      f_thread <= sel_d;
      rdata    <= rdata_d;
      done     <= done_d;
    end
  end

endmodule

// File: doc/fetch_arbiter.md
FETCH_ARBITER -- requirements
Module: fetch_arbiter

Interface
REQ-001 SHALL have parameter NTHREADS, default 4, the number of hardware-thread requesters sharing one FETCH port.
REQ-002 SHALL have parameter TIMEOUT, default 255, the watchdog limit in cycles; it is used only when FETCH_ARB_TIMEOUT_EN is defined.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  system clock; all state changes on the rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 req  in  NTHREADS  per-thread access request, level, held until done.
REQ-007 wr  in  NTHREADS  per-thread write mode (1=write, 0=read).
REQ-008 addr_i  in  32*NTHREADS  per-thread address, thread t at bits [32t+31:32t].
REQ-009 wdata_i  in  32*NTHREADS  per-thread write data, same packing as addr_i.
REQ-010 done  out  NTHREADS  one-cycle completion pulse to the granted thread.
REQ-011 err  out  1  qualifies done: access aborted by the watchdog.
REQ-012 rdata  out  32  read data, valid in the done cycle and held until the next done.
REQ-013 f_enable, f_write  out  1 each  FETCH enable and write mode.
REQ-014 f_addr, f_data  out  32 each  FETCH address and write data.
REQ-015 f_thread  out  clog2(NTHREADS)  FETCH thread select.
REQ-016 f_ack  in  1; f_rdata  in  32  FETCH acknowledge and read data.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY, DRAIN.
REQ-018 IDLE: if any req bit is set, SHALL pick a winner round-robin, starting the search at (last_grant+1) mod NTHREADS.
REQ-019 On a pick, SHALL latch the winner's wr, addr and wdata plus the thread index, assert f_enable on the next cycle and enter BUSY.
REQ-020 BUSY: f_* outputs SHALL stay constant; requester inputs are ignored.
REQ-021 BUSY with f_ack=1: SHALL capture f_rdata into rdata (reads only; writes leave rdata unchanged), pulse done[sel] for one cycle, deassert f_enable on the following cycle and enter DRAIN.
REQ-022 DRAIN: SHALL hold f_enable=0 until f_ack=0, then return to IDLE; there is no re-grant while f_ack is high.
REQ-023 Issue-to-issue minimum is 3 cycles (IDLE, BUSY, DRAIN); f_ack arriving in the first BUSY cycle yields done 1 cycle after f_enable rises.
REQ-024 A requester dropping req in BUSY SHALL NOT abort the access; done still pulses.
REQ-025 A requester SHALL drop req in the cycle after done; a req still high in IDLE counts as a new request.
REQ-026 Simultaneous requests SHALL be granted in strict rotation; no thread waits more than NTHREADS-1 grants.
REQ-027 last_grant SHALL wrap from NTHREADS-1 to 0.
REQ-028 Register-window addresses (0xFFFF_FFF0..0xFFFF_FFFF) and RAM addresses SHALL be handled identically; latency is set by f_ack only.

Reset
REQ-029 rst SHALL force state to IDLE, f_enable=0, f_write=0, f_addr=0, f_data=0, f_thread=0, done=0, err=0, rdata=0, and last_grant=NTHREADS-1 so thread 0 wins first.
REQ-030 rst asserted in BUSY SHALL drop f_enable immediately (asynchronously), and no done SHALL be issued for the aborted access.

Configuration
REQ-031 With FETCH_ARB_TIMEOUT_EN defined, an 8-bit counter SHALL run in BUSY; on reaching TIMEOUT without f_ack, the block SHALL pulse done[sel] with err=1, leave rdata unchanged, and enter DRAIN.
REQ-032 Without FETCH_ARB_TIMEOUT_EN, there is no counter, err SHALL be tied to 0, and BUSY waits indefinitely.

Structure
REQ-033 Package fetch_arb_pkg SHALL hold the state enum, NTHREADS default, REG_WINDOW_BASE=32'hFFFF_FFF0 and the thread-index width function.
REQ-034 Round-robin selection SHALL be a sub-module rr_pick (inputs req and last_grant; outputs valid and index), purely combinational.

Verification
REQ-035 Bench SHALL cover: single write, req=0001, wr=1, addr0=FFFF_FFF0, wdata0=1111_1111, f_ack one cycle later -> f_enable pulses with f_thread=0, done=0001 once.
REQ-036 Bench SHALL cover: req=1111 held continuously -> grant order 0,1,2,3,0, each access separated by DRAIN.
REQ-037 Bench SHALL cover: read from thread 2 with f_rdata=2222_2222 and f_ack delayed 5 cycles -> f_* stable for 5 cycles, rdata=2222_2222 in the done[2] cycle.
REQ-038 Bench SHALL cover: f_ack held high for 3 cycles after done -> no new f_enable until f_ack falls.
REQ-039 Bench SHALL cover: rst mid-BUSY -> f_enable=0 immediately, no done; after release, thread 0 wins first.
REQ-040 Bench SHALL cover (with FETCH_ARB_TIMEOUT_EN): f_ack never asserted, TIMEOUT=16 -> done and err pulse together 16 cycles after the issue.
